// File: rtl/calc_entry_sequencer.sv
// Keypad-to-ALU sequencer for the calculator: collects operand A, operator and operand B,
// launches the ALU with a start/done handshake and selects what the display scanner shows.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ENTER_A  | collecting operand A digits / sign, waiting for an operator
// ENTER_B  | collecting operand B digits / sign, waiting for '='
// WAIT_ALU | start pulse issued, waiting for alu_done or timeout
// RESULT   | scanner shows ALU result; a digit starts a new A
// ERROR    | scanner shows error pattern; only clear leaves
module calc_entry_sequencer #(
  parameter int NDIG        = 3,
  parameter int ALU_TIMEOUT = 255
) (
  input  logic              clk1kHz_i,
  input  logic              rst_n_i,
  input  logic              key_valid_i,
  input  logic [3:0]        key_code_i,
  input  logic              alu_done_i,
  input  logic              alu_err_i,
  output logic [4*NDIG-1:0] num1_bcd_o,
  output logic              num1_neg_o,
  output logic [4*NDIG-1:0] num2_bcd_o,
  output logic              num2_neg_o,
  output logic [1:0]        opcode_o,
  output logic              op_valid_o,
  output logic              alu_start_o,
  output logic              show_result_o,
  output logic              err_o
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  localparam int BW = 4 * NDIG;

  localparam logic [3:0] K_ADD = 4'd10;
  localparam logic [3:0] K_SUB = 4'd11;
  localparam logic [3:0] K_DIV = 4'd13;
  localparam logic [3:0] K_EQ  = 4'd14;
  localparam logic [3:0] K_CLR = 4'd15;

  typedef enum logic [2:0] {
    ENTER_A  = 3'd0,
    ENTER_B  = 3'd1,
    WAIT_ALU = 3'd2,
    RESULT   = 3'd3,
    ERROR    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   num1_q, num1_d;
  logic [BW-1:0]   num2_q, num2_d;
  logic            neg1_q, neg1_d;
  logic            neg2_q, neg2_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d;
  logic [CW-1:0]   cnt_b_q, cnt_b_d;
  logic [1:0]      opcode_q, opcode_d;
  logic            op_valid_q, op_valid_d;
  logic            alu_start_q, alu_start_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic key_digit, key_oper, key_clear, key_sub, key_eq;

  always_comb begin
    key_digit = key_valid_i && (key_code_i <= 4'd9);
    key_oper  = key_valid_i && (key_code_i >= K_ADD) && (key_code_i <= K_DIV);
    key_sub   = key_valid_i && (key_code_i == K_SUB);
    key_eq    = key_valid_i && (key_code_i == K_EQ);
    key_clear = key_valid_i && (key_code_i == K_CLR);
  end

  always_comb begin
    state_d     = state_q;
    num1_d      = num1_q;
    num2_d      = num2_q;
    neg1_d      = neg1_q;
    neg2_d      = neg2_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    opcode_d    = opcode_q;
    op_valid_d  = op_valid_q;
    alu_start_d = 1'b0;
    timer_d     = timer_q;

    if (key_clear) begin
      // clear behaves exactly like reset, from any state
      state_d    = ENTER_A;
      num1_d     = '0;
      num2_d     = '0;
      neg1_d     = 1'b0;
      neg2_d     = 1'b0;
      cnt_a_d    = '0;
      cnt_b_d    = '0;
      opcode_d   = 2'b00;
      op_valid_d = 1'b0;
      timer_d    = '0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (key_digit) begin
            if (cnt_a_q < CW'(NDIG)) begin
              num1_d  = {num1_q[BW-5:0], key_code_i};
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end else if (key_sub && (cnt_a_q == '0)) begin
            neg1_d = ~neg1_q;
          end else if (key_oper && (cnt_a_q != '0)) begin
            opcode_d   = 2'(key_code_i - K_ADD);
            op_valid_d = 1'b1;
            state_d    = ENTER_B;
          end
        end

        ENTER_B: begin
          if (key_digit) begin
            if (cnt_b_q < CW'(NDIG)) begin
              num2_d  = {num2_q[BW-5:0], key_code_i};
              cnt_b_d = cnt_b_q + 1'b1;
            end
          end else if (key_sub && (cnt_b_q == '0)) begin
            neg2_d = ~neg2_q;
          end else if (key_eq && (cnt_b_q != '0)) begin
            alu_start_d = 1'b1;
            timer_d     = '0;
            state_d     = WAIT_ALU;
          end
        end

        WAIT_ALU: begin
          // a completion in the timeout cycle still counts as completion
          if (alu_done_i) begin
            state_d = alu_err_i ? ERROR : RESULT;
          end else if (timer_q == TW'(ALU_TIMEOUT - 1)) begin
            state_d = ERROR;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        RESULT: begin
          if (key_digit) begin
            num1_d     = {{(BW-4){1'b0}}, key_code_i};
            cnt_a_d    = CW'(1);
            num2_d     = '0;
            cnt_b_d    = '0;
            neg1_d     = 1'b0;
            neg2_d     = 1'b0;
            opcode_d   = 2'b00;
            op_valid_d = 1'b0;
            state_d    = ENTER_A;
          end
        end

        ERROR: begin
          state_d = ERROR;
        end

        default: begin
          state_d = ENTER_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk1kHz_i) begin
    if (!rst_n_i) begin
      state_q     <= ENTER_A;
      num1_q      <= '0;
      num2_q      <= '0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      opcode_q    <= 2'b00;
      op_valid_q  <= 1'b0;
      alu_start_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      num1_q      <= num1_d;
      num2_q      <= num2_d;
      neg1_q      <= neg1_d;
      neg2_q      <= neg2_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      opcode_q    <= opcode_d;
      op_valid_q  <= op_valid_d;
      alu_start_q <= alu_start_d;
      timer_q     <= timer_d;
    end
  end

  assign num1_bcd_o    = num1_q;
  assign num1_neg_o    = neg1_q;
  assign num2_bcd_o    = num2_q;
  assign num2_neg_o    = neg2_q;
  assign opcode_o      = opcode_q;
  assign op_valid_o    = op_valid_q;
  assign alu_start_o   = alu_start_q;
  assign show_result_o = (state_q == RESULT);
  assign err_o         = (state_q == ERROR);

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: a digit-list reference model predicts every
// cycle's outputs, a separate monitor compares them after each rising edge.
module tb_calc_entry_sequencer;

  localparam int NDIG = 3;
  localparam int TMO  = 255;

  logic             clk;
  logic             rst_n, key_valid, alu_done, alu_err;
  logic [3:0]       key_code;
  logic [4*NDIG-1:0] num1_bcd, num2_bcd;
  logic             num1_neg, num2_neg, op_valid, alu_start, show_result, err;
  logic [1:0]       opcode;

  calc_entry_sequencer #(.NDIG(NDIG), .ALU_TIMEOUT(TMO)) dut (
    .clk1kHz_i    (clk),
    .rst_n_i      (rst_n),
    .key_valid_i  (key_valid),
    .key_code_i   (key_code),
    .alu_done_i   (alu_done),
    .alu_err_i    (alu_err),
    .num1_bcd_o   (num1_bcd),
    .num1_neg_o   (num1_neg),
    .num2_bcd_o   (num2_bcd),
    .num2_neg_o   (num2_neg),
    .opcode_o     (opcode),
    .op_valid_o   (op_valid),
    .alu_start_o  (alu_start),
    .show_result_o(show_result),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] n1;
    logic        neg1;
    logic [11:0] n2;
    logic        neg2;
    logic [1:0]  op;
    logic        opv;
    logic        start;
    logic        res;
    logic        er;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   seen_starts = 0;
  int   model_starts = 0;

  // reference model: phase 0=A entry, 1=B entry, 2=waiting for ALU, 3=result, 4=error
  int   m_phase;
  int   m_da[$];
  int   m_db[$];
  bit   m_neg1, m_neg2, m_opv, m_start;
  int   m_op;
  int   m_waited;

  function automatic logic [11:0] digits_to_bcd(input int d[$]);
    int v = 0;
    foreach (d[i]) v = v * 16 + d[i];
    return 12'(v);
  endfunction

  function automatic void model_clear();
    m_phase = 0; m_da.delete(); m_db.delete();
    m_neg1 = 0; m_neg2 = 0; m_opv = 0; m_op = 0; m_waited = 0;
  endfunction

  function automatic void model_step(input bit rs, input bit kv, input int kc,
                                     input bit dn, input bit de);
    bit next_start = 0;
    if (!rs || (kv && kc == 15)) begin
      model_clear();
    end else begin
      case (m_phase)
        0: if (kv) begin
             if (kc < 10) begin
               if (m_da.size() < NDIG) m_da.push_back(kc);
             end else if (kc == 11 && m_da.size() == 0) m_neg1 = !m_neg1;
             else if (kc >= 10 && kc <= 13 && m_da.size() > 0) begin
               m_op = kc - 10; m_opv = 1; m_phase = 1;
             end
           end
        1: if (kv) begin
             if (kc < 10) begin
               if (m_db.size() < NDIG) m_db.push_back(kc);
             end else if (kc == 11 && m_db.size() == 0) m_neg2 = !m_neg2;
             else if (kc == 14 && m_db.size() > 0) begin
               next_start = 1; m_waited = 0; m_phase = 2;
               model_starts++;
             end
           end
        2: begin
             if (dn) m_phase = de ? 4 : 3;
             else begin
               m_waited++;
               if (m_waited == TMO) m_phase = 4;
             end
           end
        3: if (kv && kc < 10) begin
             model_clear();
             m_da.push_back(kc);
           end
        default: ;
      endcase
    end
    m_start = next_start;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.n1 = digits_to_bcd(m_da); e.neg1 = m_neg1;
    e.n2 = digits_to_bcd(m_db); e.neg2 = m_neg2;
    e.op = 2'(m_op); e.opv = m_opv; e.start = m_start;
    e.res = (m_phase == 3); e.er = (m_phase == 4);
    return e;
  endfunction

  task automatic tick(input bit rs, input bit kv, input int kc, input bit dn, input bit de);
    @(negedge clk);
    rst_n = rs; key_valid = kv; key_code = 4'(kc); alu_done = dn; alu_err = de;
    model_step(rs, kv, kc, dn, de);
    exp_q.push_back(model_out());
  endtask

  task automatic key(input int kc);
    tick(1, 1, kc, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL cycle %0d %s: got %0h expected %0h", cyc, nm, got, want);
    end
  endtask

  // monitor: outputs are continuously presented, so every rising edge yields one sample
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (alu_start === 1'b1) seen_starts++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("num1_bcd", 32'(num1_bcd), 32'(e.n1));
        check("num1_neg", 32'(num1_neg), 32'(e.neg1));
        check("num2_bcd", 32'(num2_bcd), 32'(e.n2));
        check("num2_neg", 32'(num2_neg), 32'(e.neg2));
        check("opcode", 32'(opcode), 32'(e.op));
        check("op_valid", 32'(op_valid), 32'(e.opv));
        check("alu_start", 32'(alu_start), 32'(e.start));
        check("show_result", 32'(show_result), 32'(e.res));
        check("err", 32'(err), 32'(e.er));
      end
    end
  end

  initial begin
    rst_n = 0; key_valid = 0; key_code = 0; alu_done = 0; alu_err = 0;
    model_clear();
    m_start = 0;

    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    // 12 + 3 =
    key(1); key(2); key(10); key(3); key(14);
    idle(3);
    tick(1, 0, 0, 1, 0);
    // negative operands, subtract
    key(15);
    key(11); key(4); key(11); key(11); key(5); key(14);
    idle(2);
    tick(1, 0, 0, 1, 0);
    // fourth digit dropped, '=' in A ignored
    key(15);
    key(9); key(9); key(9); key(9); key(14);
    idle(2);
    // divide with no ALU response -> timeout
    key(13); key(2); key(14);
    idle(TMO + 5);
    key(15);
    idle(2);
    // done+err in the timeout cycle
    key(1); key(10); key(2); key(14);
    idle(TMO - 1);
    tick(1, 0, 0, 1, 1);
    idle(2);
    key(15);
    // clean done in the timeout cycle wins, then new entry from RESULT
    key(1); key(10); key(2); key(14);
    idle(TMO - 1);
    tick(1, 0, 0, 1, 0);
    idle(2);
    key(10); key(14);
    key(7);
    idle(2);
    // reset mid-wait, late done ignored
    key(15);
    key(1); key(10); key(2); key(14);
    idle(5);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0);
    idle(2);

    for (int i = 0; i < 4000; i++) begin
      bit kv, dn, de, rs;
      int kc;
      kv = ($urandom_range(0, 2) == 0);
      kc = $urandom_range(0, 15);
      if (kc == 15 && $urandom_range(0, 3) != 0) kc = 14;
      dn = ($urandom_range(0, 15) == 0);
      de = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 299) != 0);
      tick(rs, kv, kc, dn, de);
    end

    // long quiet stretch after a launch so the random phase also meets a timeout
    key(15); key(5); key(12); key(6); key(14);
    idle(TMO + 3);

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("start_pulses", 32'(seen_starts), 32'(model_starts));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
